// File: rtl/traffic_sequencer_pkg.sv
// traffic_pkg: state encodings, lamp constants, lamp bit indices and default
// phase durations shared by the traffic_sequencer block and its phase timer.
// No ports; imported with "import traffic_pkg::*;".
package traffic_pkg;

  // Seven legal states; encoding 3'd7 is illegal and recovered to ST_RED_B.
  typedef enum logic [2:0] {
    ST_MAIN_G = 3'd0,
    ST_MAIN_Y = 3'd1,
    ST_RED_A  = 3'd2,
    ST_SIDE_G = 3'd3,
    ST_SIDE_Y = 3'd4,
    ST_RED_B  = 3'd5,
    ST_WALK   = 3'd6
  } state_t;

  // Bit positions inside light_signals = {Rm,Ym,Gm,Rs,Ys,Gs,W}.
  localparam int unsigned LS_RM = 6;
  localparam int unsigned LS_YM = 5;
  localparam int unsigned LS_GM = 4;
  localparam int unsigned LS_RS = 3;
  localparam int unsigned LS_YS = 2;
  localparam int unsigned LS_GS = 1;
  localparam int unsigned LS_W  = 0;

  // Lamp patterns per state.
  localparam logic [6:0] LS_MAIN_G = 7'b0011000;
  localparam logic [6:0] LS_MAIN_Y = 7'b0101000;
  localparam logic [6:0] LS_RED_A  = 7'b1001000;
  localparam logic [6:0] LS_SIDE_G = 7'b1000010;
  localparam logic [6:0] LS_SIDE_Y = 7'b1000100;
  localparam logic [6:0] LS_RED_B  = 7'b1001000;
  localparam logic [6:0] LS_WALK   = 7'b1001001;

  // Default phase durations in ticks (legal range 1..255).
  localparam int unsigned DEF_T_MAIN_MIN = 10;
  localparam int unsigned DEF_T_YELLOW   = 3;
  localparam int unsigned DEF_T_RED      = 1;
  localparam int unsigned DEF_T_SIDE     = 8;
  localparam int unsigned DEF_T_WALK     = 6;

  // Lamp pattern for a state; an illegal code shows the all-red pattern of
  // ST_RED_B, which is where the sequencer recovers to.
  function automatic logic [6:0] decode_lights(input state_t st);
    logic [6:0] ls;
    case (st)
      ST_MAIN_G: ls = LS_MAIN_G;
      ST_MAIN_Y: ls = LS_MAIN_Y;
      ST_RED_A:  ls = LS_RED_A;
      ST_SIDE_G: ls = LS_SIDE_G;
      ST_SIDE_Y: ls = LS_SIDE_Y;
      ST_RED_B:  ls = LS_RED_B;
      ST_WALK:   ls = LS_WALK;
      default:   ls = LS_RED_B;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/traffic_sequencer_phase_timer.sv
// phase_timer: 8-bit phase counter. Clears when the owning FSM changes state,
// counts ticks otherwise, and saturates at T-1 so a state that waits for an
// extra condition (main green) stays expired until it may leave.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset
//   i_clear   - state is changing on this edge; timer returns to 0
//   i_tick    - timebase enable
//   i_t       - duration of the current state in ticks (1..255)
//   o_expired - this edge is the last tick of the state (tick=1, timer=T-1)
module phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_tick,
  input  logic [7:0] i_t,
  output logic       o_expired
);

  logic [7:0] r_timer;
  logic       w_last;

  // Timer at its final count; also the saturation point.
  always_comb begin
    w_last    = (r_timer == (i_t - 8'd1));
    o_expired = i_tick & w_last;
  end

  // Phase counter: clear on state change, count ticks, hold at T-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer <= 8'd0;
    end else if (i_clear) begin
      r_timer <= 8'd0;
    end else if (i_tick && !w_last) begin
      r_timer <= r_timer + 8'd1;
    end else begin
      r_timer <= r_timer;
    end
  end

endmodule

// File: rtl/traffic_sequencer.sv
// traffic_sequencer: main-road / side-road / pedestrian lamp sequencer.
// Main road rests green; latched side or walk requests are served after the
// minimum main-green time, via yellow and all-red clearance phases.
// Ports:
//   clk           - system clock, rising edge
//   rst_n         - synchronous active-low reset
//   tick          - timebase enable; phase timers advance only when 1
//   side_req      - side-road vehicle sensor (level)
//   ped_req       - pedestrian button (pulse or level)
//   light_signals - registered lamps {Rm,Ym,Gm,Rs,Ys,Gs,W}
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned T_MAIN_MIN = DEF_T_MAIN_MIN,
  parameter int unsigned T_YELLOW   = DEF_T_YELLOW,
  parameter int unsigned T_RED      = DEF_T_RED,
  parameter int unsigned T_SIDE     = DEF_T_SIDE,
  parameter int unsigned T_WALK     = DEF_T_WALK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [6:0] light_signals
);

  localparam logic [7:0] W_T_MAIN_MIN = 8'(T_MAIN_MIN);
  localparam logic [7:0] W_T_YELLOW   = 8'(T_YELLOW);
  localparam logic [7:0] W_T_RED      = 8'(T_RED);
  localparam logic [7:0] W_T_SIDE     = 8'(T_SIDE);
  localparam logic [7:0] W_T_WALK     = 8'(T_WALK);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_side_pend;
  logic       r_ped_pend;
  logic [6:0] r_light;
  logic [7:0] w_phase_t;
  logic       w_expired;
  logic       w_state_chg;
  logic       w_enter_side;
  logic       w_enter_walk;

  // Duration of the current state for the phase timer.
  always_comb begin
    case (r_state)
      ST_MAIN_G: w_phase_t = W_T_MAIN_MIN;
      ST_MAIN_Y: w_phase_t = W_T_YELLOW;
      ST_RED_A:  w_phase_t = W_T_RED;
      ST_SIDE_G: w_phase_t = W_T_SIDE;
      ST_SIDE_Y: w_phase_t = W_T_YELLOW;
      ST_RED_B:  w_phase_t = W_T_RED;
      ST_WALK:   w_phase_t = W_T_WALK;
      default:   w_phase_t = W_T_RED;
    endcase
  end

  phase_timer u_phase_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_state_chg),
    .i_tick    (tick),
    .i_t       (w_phase_t),
    .o_expired (w_expired)
  );

  // Next-state logic and the pend-clear strobes derived from it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_MAIN_G: begin
        // Main green holds (timer saturated) until something is pending.
        if (w_expired && (r_side_pend || r_ped_pend)) begin
          w_next_state = ST_MAIN_Y;
        end else begin
          w_next_state = ST_MAIN_G;
        end
      end
      ST_MAIN_Y: w_next_state = w_expired ? ST_RED_A : ST_MAIN_Y;
      ST_RED_A: begin
        if (w_expired) begin
          w_next_state = r_side_pend ? ST_SIDE_G : ST_WALK;
        end else begin
          w_next_state = ST_RED_A;
        end
      end
      ST_SIDE_G: w_next_state = w_expired ? ST_SIDE_Y : ST_SIDE_G;
      ST_SIDE_Y: w_next_state = w_expired ? ST_RED_B : ST_SIDE_Y;
      ST_RED_B: begin
        if (w_expired) begin
          w_next_state = r_ped_pend ? ST_WALK : ST_MAIN_G;
        end else begin
          w_next_state = ST_RED_B;
        end
      end
      ST_WALK:   w_next_state = w_expired ? ST_MAIN_G : ST_WALK;
      // Illegal encoding: all-red recovery; state change clears the timer.
      default:   w_next_state = ST_RED_B;
    endcase
    w_state_chg  = (w_next_state != r_state);
    w_enter_side = (w_next_state == ST_SIDE_G) && (r_state != ST_SIDE_G);
    w_enter_walk = (w_next_state == ST_WALK)   && (r_state != ST_WALK);
  end

  // State, request latches and registered lamp decode of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_MAIN_G;
      r_side_pend <= 1'b0;
      r_ped_pend  <= 1'b0;
      r_light     <= LS_MAIN_G;
    end else begin
      r_state     <= w_next_state;
      // Clear on entry wins over a request seen on the same edge.
      r_side_pend <= w_enter_side ? 1'b0 : (r_side_pend | side_req);
      r_ped_pend  <= w_enter_walk ? 1'b0 : (r_ped_pend | ped_req);
      r_light     <= decode_lights(w_next_state);
    end
  end

  assign light_signals = r_light;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer with short phase timings.
module tb_traffic_sequencer;

  localparam logic [6:0] MG = 7'b0011000;
  localparam logic [6:0] MY = 7'b0101000;
  localparam logic [6:0] RA = 7'b1001000;
  localparam logic [6:0] SG = 7'b1000010;
  localparam logic [6:0] SY = 7'b1000100;
  localparam logic [6:0] RB = 7'b1001000;
  localparam logic [6:0] WK = 7'b1001001;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       side_req;
  logic       ped_req;
  logic [6:0] light_signals;

  int n_vec;
  int n_err;
  int edge_cnt;
  bit div4;

  traffic_sequencer #(
    .T_MAIN_MIN (4),
    .T_YELLOW   (2),
    .T_RED      (1),
    .T_SIDE     (3),
    .T_WALK     (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .side_req      (side_req),
    .ped_req       (ped_req),
    .light_signals (light_signals)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d got=%b want=%b", tag, edge_cnt, obs, exp);
    end
  endtask

  // One clock edge; tick is set up beforehand, outputs sampled 1 ns after.
  task automatic step();
    tick = div4 ? (((edge_cnt + 1) % 4) == 0) : 1'b1;
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic expect_run(input string tag, input logic [6:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_vec(tag, light_signals, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    side_req = 1'b0;
    ped_req  = 1'b0;
    div4     = 1'b0;
    step();
    check_vec("reset", light_signals, MG);
    rst_n    = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    edge_cnt = 0;
    div4     = 1'b0;
    rst_n    = 1'b0;
    tick     = 1'b1;
    side_req = 1'b0;
    ped_req  = 1'b0;
    @(negedge clk);

    // Idle: main green forever.
    do_reset();
    expect_run("idle_mg", MG, 20);

    // Side request one clk.
    do_reset();
    side_req = 1'b1;
    expect_run("side_mg", MG, 1);
    side_req = 1'b0;
    expect_run("side_mg", MG, 2);
    expect_run("side_my", MY, 2);
    expect_run("side_ra", RA, 1);
    expect_run("side_sg", SG, 3);
    expect_run("side_sy", SY, 2);
    expect_run("side_rb", RB, 1);
    expect_run("side_mg2", MG, 6);

    // Pedestrian pulse only.
    do_reset();
    ped_req = 1'b1;
    expect_run("ped_mg", MG, 1);
    ped_req = 1'b0;
    expect_run("ped_mg", MG, 2);
    expect_run("ped_my", MY, 2);
    expect_run("ped_ra", RA, 1);
    expect_run("ped_wk", WK, 3);
    expect_run("ped_mg2", MG, 6);

    // Both together: side first, walk straight after RED_B.
    do_reset();
    side_req = 1'b1;
    ped_req  = 1'b1;
    expect_run("both_mg", MG, 1);
    side_req = 1'b0;
    ped_req  = 1'b0;
    expect_run("both_mg", MG, 2);
    expect_run("both_my", MY, 2);
    expect_run("both_ra", RA, 1);
    expect_run("both_sg", SG, 3);
    expect_run("both_sy", SY, 2);
    expect_run("both_rb", RB, 1);
    expect_run("both_wk", WK, 3);
    expect_run("both_mg2", MG, 8);
    check_vec("both_pends", {5'd0, dut.r_side_pend, dut.r_ped_pend}, 7'd0);

    // Tick every 4th clk, side held: phases 4x long, second side cycle.
    do_reset();
    div4     = 1'b1;
    side_req = 1'b1;
    expect_run("div4_mg", MG, 15);
    expect_run("div4_my", MY, 8);
    expect_run("div4_ra", RA, 4);
    expect_run("div4_sg", SG, 12);
    expect_run("div4_sy", SY, 8);
    expect_run("div4_rb", RB, 4);
    expect_run("div4_mg2", MG, 16);
    expect_run("div4_my2", MY, 8);
    expect_run("div4_ra2", RA, 4);
    expect_run("div4_sg2", SG, 4);
    side_req = 1'b0;
    div4     = 1'b0;

    // Reset during SIDE_Y with a walk still pending.
    do_reset();
    side_req = 1'b1;
    ped_req  = 1'b1;
    expect_run("rst_mg", MG, 1);
    side_req = 1'b0;
    ped_req  = 1'b0;
    expect_run("rst_mg", MG, 2);
    expect_run("rst_my", MY, 2);
    expect_run("rst_ra", RA, 1);
    expect_run("rst_sg", SG, 3);
    expect_run("rst_sy", SY, 1);
    check_vec("rst_pre_pends", {5'd0, dut.r_side_pend, dut.r_ped_pend}, 7'b0000001);
    rst_n = 1'b0;
    expect_run("rst_mid_sy", MG, 1);
    check_vec("rst_pends", {5'd0, dut.r_side_pend, dut.r_ped_pend}, 7'd0);
    rst_n = 1'b1;
    expect_run("rst_after", MG, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
